// File: rtl/dahb_mem_arb.sv
// -----------------------------------------------------------------------------
// dahb_mem_arb
// Two-master AHB-lite arbiter in front of a single memory controller slave.
// Master 0 is the instruction side and master 1 is the data side.
//
// A live request is forwarded to the slave in the same cycle when it is the
// only candidate. A request that cannot be forwarded is captured into a
// per-master pending register and issued at a later slave-ready cycle.
// Pending entries always beat new requests. Ties within a class go to the
// master that did not win the last grant.
//
// Ports
//   pll_core_cpuclk            core clock, all state on the rising edge
//   pad_cpu_rst                asynchronous active-high reset
//   mX_arb_hsel/haddr/hsize/htrans/hwrite/hwdata  master X AHB-lite request
//   arb_mX_hrdata/hready/hresp                    master X response
//   arb_mmc_hsel, arb_yy_haddr/hsize/htrans/hwrite/hwdata  slave request
//   mmc_arb_hrdata/hready/hresp                   slave response
// -----------------------------------------------------------------------------
module dahb_mem_arb (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst,
    // master 0 (instruction side)
    input  logic        m0_arb_hsel,
    input  logic [31:0] m0_arb_haddr,
    input  logic [2:0]  m0_arb_hsize,
    input  logic [1:0]  m0_arb_htrans,
    input  logic        m0_arb_hwrite,
    input  logic [31:0] m0_arb_hwdata,
    output logic [31:0] arb_m0_hrdata,
    output logic        arb_m0_hready,
    output logic [1:0]  arb_m0_hresp,
    // master 1 (data side)
    input  logic        m1_arb_hsel,
    input  logic [31:0] m1_arb_haddr,
    input  logic [2:0]  m1_arb_hsize,
    input  logic [1:0]  m1_arb_htrans,
    input  logic        m1_arb_hwrite,
    input  logic [31:0] m1_arb_hwdata,
    output logic [31:0] arb_m1_hrdata,
    output logic        arb_m1_hready,
    output logic [1:0]  arb_m1_hresp,
    // memory controller side
    output logic        arb_mmc_hsel,
    output logic [31:0] arb_yy_haddr,
    output logic [2:0]  arb_yy_hsize,
    output logic [1:0]  arb_yy_htrans,
    output logic        arb_yy_hwrite,
    output logic [31:0] arb_yy_hwdata,
    input  logic [31:0] mmc_arb_hrdata,
    input  logic        mmc_arb_hready,
    input  logic [1:0]  mmc_arb_hresp
);

    // Data-phase ownership
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DP0  = 2'd1,
        ST_DP1  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;   // 1'b0 = m0 won last, 1'b1 = m1 won last
    logic [1:0]  r_pend_vld;
    logic [31:0] r_pend_addr0;
    logic [31:0] r_pend_addr1;
    logic [2:0]  r_pend_size0;
    logic [2:0]  r_pend_size1;
    logic        r_pend_write0;
    logic        r_pend_write1;

    logic        w_own0;
    logic        w_own1;
    logic        w_base_rdy0;
    logic        w_base_rdy1;
    logic        w_req0;
    logic        w_req1;
    logic        w_issue;
    logic        w_win;          // winning master index
    logic        w_from_pend;    // winner comes from its pending register
    logic        w_cap0;
    logic        w_cap1;
    logic        w_unused_htrans;

    // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
    assign w_unused_htrans = m0_arb_htrans[0] ^ m1_arb_htrans[0];

    assign w_own0 = (r_state == ST_DP0);
    assign w_own1 = (r_state == ST_DP1);

    // hready seen by a master before accounting for a capture in this cycle.
    // Used to qualify requests so the capture term does not loop back.
    // Reset forces it high so masters see a ready bus while reset is held.
    always_comb begin
        w_base_rdy0 = 1'b1;
        w_base_rdy1 = 1'b1;
        if (pad_cpu_rst) begin
            w_base_rdy0 = 1'b1;
            w_base_rdy1 = 1'b1;
        end else begin
            if (w_own0) begin
                w_base_rdy0 = mmc_arb_hready;
            end else if (r_pend_vld[0]) begin
                w_base_rdy0 = 1'b0;
            end else begin
                w_base_rdy0 = 1'b1;
            end
            if (w_own1) begin
                w_base_rdy1 = mmc_arb_hready;
            end else if (r_pend_vld[1]) begin
                w_base_rdy1 = 1'b0;
            end else begin
                w_base_rdy1 = 1'b1;
            end
        end
    end

    // IDLE/BUSY transfers never form a request
    assign w_req0 = ~pad_cpu_rst & m0_arb_hsel & m0_arb_htrans[1] & w_base_rdy0;
    assign w_req1 = ~pad_cpu_rst & m1_arb_hsel & m1_arb_htrans[1] & w_base_rdy1;

    // Pick the winner: pending before live, tie goes to the master not last granted
    always_comb begin
        w_issue     = 1'b0;
        w_win       = 1'b0;
        w_from_pend = 1'b0;
        if (pad_cpu_rst) begin
            w_issue = 1'b0;
        end else if (mmc_arb_hready) begin
            if (r_pend_vld != 2'b00) begin
                w_issue     = 1'b1;
                w_from_pend = 1'b1;
                w_win       = (r_pend_vld == 2'b11) ? ~r_last_grant : r_pend_vld[1];
            end else if (w_req0 | w_req1) begin
                w_issue = 1'b1;
                w_win   = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
            end else begin
                w_issue = 1'b0;
            end
        end else begin
            w_issue = 1'b0;
        end
    end

    // A live request that is not the live winner goes to its pending register
    assign w_cap0 = w_req0 & ~(w_issue & ~w_from_pend & ~w_win);
    assign w_cap1 = w_req1 & ~(w_issue & ~w_from_pend &  w_win);

    // Slave address-phase mux
    always_comb begin
        arb_mmc_hsel  = 1'b0;
        arb_yy_htrans = 2'b00;
        arb_yy_haddr  = 32'h0000_0000;
        arb_yy_hsize  = 3'b000;
        arb_yy_hwrite = 1'b0;
        if (w_issue) begin
            arb_mmc_hsel  = 1'b1;
            arb_yy_htrans = 2'b10;
            case ({w_from_pend, w_win})
                2'b00: begin
                    arb_yy_haddr  = m0_arb_haddr;
                    arb_yy_hsize  = m0_arb_hsize;
                    arb_yy_hwrite = m0_arb_hwrite;
                end
                2'b01: begin
                    arb_yy_haddr  = m1_arb_haddr;
                    arb_yy_hsize  = m1_arb_hsize;
                    arb_yy_hwrite = m1_arb_hwrite;
                end
                2'b10: begin
                    arb_yy_haddr  = r_pend_addr0;
                    arb_yy_hsize  = r_pend_size0;
                    arb_yy_hwrite = r_pend_write0;
                end
                2'b11: begin
                    arb_yy_haddr  = r_pend_addr1;
                    arb_yy_hsize  = r_pend_size1;
                    arb_yy_hwrite = r_pend_write1;
                end
                default: begin
                    arb_yy_haddr  = 32'h0000_0000;
                    arb_yy_hsize  = 3'b000;
                    arb_yy_hwrite = 1'b0;
                end
            endcase
        end else begin
            arb_mmc_hsel  = 1'b0;
            arb_yy_htrans = 2'b00;
        end
    end

    // Write data follows data-phase ownership
    always_comb begin
        arb_yy_hwdata = 32'h0000_0000;
        case (r_state)
            ST_DP0:  arb_yy_hwdata = m0_arb_hwdata;
            ST_DP1:  arb_yy_hwdata = m1_arb_hwdata;
            default: arb_yy_hwdata = 32'h0000_0000;
        endcase
    end

    // Responses: owner sees the slave, a capturing master is held off.
    // The owner term wins over capture so a completing data phase is not stretched.
    assign arb_m0_hready = w_base_rdy0 & (w_own0 | ~w_cap0);
    assign arb_m1_hready = w_base_rdy1 & (w_own1 | ~w_cap1);
    assign arb_m0_hresp  = w_own0 ? mmc_arb_hresp : 2'b00;
    assign arb_m1_hresp  = w_own1 ? mmc_arb_hresp : 2'b00;
    assign arb_m0_hrdata = mmc_arb_hrdata;
    assign arb_m1_hrdata = mmc_arb_hrdata;

    // FSM, grant history and pending registers
    always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_pend_vld    <= 2'b00;
            r_pend_addr0  <= 32'h0000_0000;
            r_pend_addr1  <= 32'h0000_0000;
            r_pend_size0  <= 3'b000;
            r_pend_size1  <= 3'b000;
            r_pend_write0 <= 1'b0;
            r_pend_write1 <= 1'b0;
        end else begin
            // Ownership only moves when the slave accepts
            if (mmc_arb_hready) begin
                if (w_issue) begin
                    r_state <= w_win ? ST_DP1 : ST_DP0;
                end else begin
                    r_state <= ST_IDLE;
                end
            end

            if (w_issue) begin
                r_last_grant <= w_win;
            end

            if (w_issue & w_from_pend & ~w_win) begin
                r_pend_vld[0] <= 1'b0;
            end else if (w_cap0) begin
                r_pend_vld[0] <= 1'b1;
                r_pend_addr0  <= m0_arb_haddr;
                r_pend_size0  <= m0_arb_hsize;
                r_pend_write0 <= m0_arb_hwrite;
            end

            if (w_issue & w_from_pend & w_win) begin
                r_pend_vld[1] <= 1'b0;
            end else if (w_cap1) begin
                r_pend_vld[1] <= 1'b1;
                r_pend_addr1  <= m1_arb_haddr;
                r_pend_size1  <= m1_arb_hsize;
                r_pend_write1 <= m1_arb_hwrite;
            end
        end
    end

endmodule

// File: tb/tb_dahb_mem_arb.sv
module tb_dahb_mem_arb;

    logic        clk;
    logic        rst;
    logic        m0_hsel, m1_hsel;
    logic [31:0] m0_haddr, m1_haddr;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready;
    logic [1:0]  m0_hresp, m1_hresp;
    logic        s_hsel;
    logic [31:0] s_haddr;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [31:0] s_hwdata;
    logic [31:0] mmc_hrdata;
    logic        mmc_hready;
    logic [1:0]  mmc_hresp;

    int n_checks = 0;
    int n_errors = 0;

    dahb_mem_arb dut (
        .pll_core_cpuclk (clk),
        .pad_cpu_rst     (rst),
        .m0_arb_hsel     (m0_hsel),
        .m0_arb_haddr    (m0_haddr),
        .m0_arb_hsize    (m0_hsize),
        .m0_arb_htrans   (m0_htrans),
        .m0_arb_hwrite   (m0_hwrite),
        .m0_arb_hwdata   (m0_hwdata),
        .arb_m0_hrdata   (m0_hrdata),
        .arb_m0_hready   (m0_hready),
        .arb_m0_hresp    (m0_hresp),
        .m1_arb_hsel     (m1_hsel),
        .m1_arb_haddr    (m1_haddr),
        .m1_arb_hsize    (m1_hsize),
        .m1_arb_htrans   (m1_htrans),
        .m1_arb_hwrite   (m1_hwrite),
        .m1_arb_hwdata   (m1_hwdata),
        .arb_m1_hrdata   (m1_hrdata),
        .arb_m1_hready   (m1_hready),
        .arb_m1_hresp    (m1_hresp),
        .arb_mmc_hsel    (s_hsel),
        .arb_yy_haddr    (s_haddr),
        .arb_yy_hsize    (s_hsize),
        .arb_yy_htrans   (s_htrans),
        .arb_yy_hwrite   (s_hwrite),
        .arb_yy_hwdata   (s_hwdata),
        .mmc_arb_hrdata  (mmc_hrdata),
        .mmc_arb_hready  (mmc_hready),
        .mmc_arb_hresp   (mmc_hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_m0(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                          input logic [31:0] wd);
        m0_hsel = sel; m0_htrans = tr; m0_haddr = a; m0_hwdata = wd;
        m0_hsize = 3'd2; m0_hwrite = 1'b1;
    endtask

    task automatic drv_m1(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                          input logic [31:0] wd);
        m1_hsel = sel; m1_htrans = tr; m1_haddr = a; m1_hwdata = wd;
        m1_hsize = 3'd2; m1_hwrite = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        mmc_hready = 1'b1; mmc_hresp = 2'b00; mmc_hrdata = 32'h0;
        drv_m0(1'b0, 2'b00, 32'h0, 32'h0);
        drv_m1(1'b1, 2'b10, 32'h0000_0040, 32'h0);
        #3;
        // reset state, with a live m1 request held during reset
        chk("rst_hsel",    32'(s_hsel), 32'd0);
        chk("rst_htrans",  32'(s_htrans), 32'd0);
        chk("rst_hwdata",  s_hwdata, 32'd0);
        chk("rst_m0_rdy",  32'(m0_hready), 32'd1);
        chk("rst_m1_rdy",  32'(m1_hready), 32'd1);
        chk("rst_m0_resp", 32'(m0_hresp), 32'd0);
        chk("rst_m1_resp", 32'(m1_hresp), 32'd0);
        drv_m1(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // single m1 write
        drv_m1(1'b1, 2'b10, 32'h2000_0010, 32'hDEAD_BEEF);
        #2;
        chk("w1_hsel",   32'(s_hsel), 32'd1);
        chk("w1_htrans", 32'(s_htrans), 32'd2);
        chk("w1_haddr",  s_haddr, 32'h2000_0010);
        chk("w1_hsize",  32'(s_hsize), 32'd2);
        chk("w1_hwrite", 32'(s_hwrite), 32'd1);
        chk("w1_m1_rdy", 32'(m1_hready), 32'd1);
        tick();
        m1_hsel = 1'b0; m1_htrans = 2'b00;
        mmc_hresp = 2'b01; mmc_hrdata = 32'hCAFE_F00D;
        #2;
        chk("w1_dp_hwdata", s_hwdata, 32'hDEAD_BEEF);
        chk("w1_dp_hsel",   32'(s_hsel), 32'd0);
        chk("w1_m1_resp",   32'(m1_hresp), 32'd1);
        chk("w1_m0_resp",   32'(m0_hresp), 32'd0);
        chk("w1_m0_rdata",  m0_hrdata, 32'hCAFE_F00D);
        chk("w1_m1_rdata",  m1_hrdata, 32'hCAFE_F00D);
        tick();
        mmc_hresp = 2'b00;
        #2;
        chk("w1_idle_hwdata", s_hwdata, 32'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();

        // simultaneous requests, alternating grants from reset
        drv_m0(1'b1, 2'b10, 32'h0000_0100, 32'h1111_1111);
        drv_m1(1'b1, 2'b10, 32'h0000_0200, 32'h2222_2222);
        #2;
        chk("alt0_haddr", s_haddr, 32'h0000_0100);
        chk("alt0_m0_rdy", 32'(m0_hready), 32'd1);
        chk("alt0_m1_rdy", 32'(m1_hready), 32'd0);
        tick();
        #1;
        chk("alt1_hsel",  32'(s_hsel), 32'd1);
        chk("alt1_haddr", s_haddr, 32'h0000_0200);
        chk("alt1_m1_rdy", 32'(m1_hready), 32'd0);
        chk("alt1_m0_rdy", 32'(m0_hready), 32'd1);
        chk("alt1_hwdata", s_hwdata, 32'h1111_1111);
        tick();
        #1;
        chk("alt2_haddr", s_haddr, 32'h0000_0100);
        chk("alt2_m0_rdy", 32'(m0_hready), 32'd0);
        chk("alt2_m1_rdy", 32'(m1_hready), 32'd1);
        chk("alt2_hwdata", s_hwdata, 32'h2222_2222);
        tick();
        #1;
        chk("alt3_haddr", s_haddr, 32'h0000_0200);
        chk("alt3_hwdata", s_hwdata, 32'h1111_1111);
        tick();
        m0_hsel = 1'b0; m0_htrans = 2'b00;
        m1_hsel = 1'b0; m1_htrans = 2'b00;
        #1;
        chk("alt4_hsel",  32'(s_hsel), 32'd1);
        chk("alt4_haddr", s_haddr, 32'h0000_0100);
        chk("alt4_hwdata", s_hwdata, 32'h2222_2222);
        tick();
        #1;
        chk("alt5_hsel",  32'(s_hsel), 32'd0);
        chk("alt5_hwdata", s_hwdata, 32'h1111_1111);
        tick();

        // slave stall in DP1 while m0 requests
        drv_m1(1'b1, 2'b10, 32'h0000_0300, 32'h3333_3333);
        #2;
        chk("st0_haddr", s_haddr, 32'h0000_0300);
        tick();
        m1_hsel = 1'b0; m1_htrans = 2'b00;
        mmc_hready = 1'b0; mmc_hresp = 2'b10;
        drv_m0(1'b1, 2'b10, 32'h0000_0400, 32'h4444_4444);
        #2;
        chk("st1_hsel",   32'(s_hsel), 32'd0);
        chk("st1_m0_rdy", 32'(m0_hready), 32'd0);
        chk("st1_m1_rdy", 32'(m1_hready), 32'd0);
        chk("st1_m1_resp", 32'(m1_hresp), 32'd2);
        chk("st1_hwdata", s_hwdata, 32'h3333_3333);
        tick();
        #1;
        chk("st2_hsel",   32'(s_hsel), 32'd0);
        chk("st2_m0_rdy", 32'(m0_hready), 32'd0);
        chk("st2_hwdata", s_hwdata, 32'h3333_3333);
        tick();
        #1;
        chk("st3_hsel", 32'(s_hsel), 32'd0);
        tick();
        mmc_hready = 1'b1; mmc_hresp = 2'b00;
        #1;
        chk("st4_hsel",   32'(s_hsel), 32'd1);
        chk("st4_haddr",  s_haddr, 32'h0000_0400);
        chk("st4_m0_rdy", 32'(m0_hready), 32'd0);
        chk("st4_m1_rdy", 32'(m1_hready), 32'd1);
        tick();
        m0_hsel = 1'b0; m0_htrans = 2'b00;
        #1;
        chk("st5_hsel",   32'(s_hsel), 32'd0);
        chk("st5_m0_rdy", 32'(m0_hready), 32'd1);
        chk("st5_hwdata", s_hwdata, 32'h4444_4444);
        tick();

        // reset while m1 is pending
        mmc_hready = 1'b0;
        drv_m1(1'b1, 2'b10, 32'h0000_0500, 32'h5555_5555);
        #2;
        chk("rp0_hsel",   32'(s_hsel), 32'd0);
        chk("rp0_m1_rdy", 32'(m1_hready), 32'd0);
        tick();
        m1_hsel = 1'b0; m1_htrans = 2'b00;
        #1;
        chk("rp1_m1_rdy", 32'(m1_hready), 32'd0);
        rst = 1'b1;
        mmc_hready = 1'b1;
        #1;
        chk("rp2_m1_rdy",  32'(m1_hready), 32'd1);
        chk("rp2_m0_rdy",  32'(m0_hready), 32'd1);
        chk("rp2_hsel",    32'(s_hsel), 32'd0);
        chk("rp2_htrans",  32'(s_htrans), 32'd0);
        rst = 1'b0;
        #1;
        chk("rp3_hsel",   32'(s_hsel), 32'd0);
        chk("rp3_m1_rdy", 32'(m1_hready), 32'd1);
        tick();
        #1;
        chk("rp4_hsel",   32'(s_hsel), 32'd0);
        chk("rp4_hwdata", s_hwdata, 32'd0);
        tick();

        // BUSY transfer makes no request
        drv_m0(1'b1, 2'b01, 32'h0000_0600, 32'h0);
        #2;
        chk("busy0_hsel",   32'(s_hsel), 32'd0);
        chk("busy0_m0_rdy", 32'(m0_hready), 32'd1);
        tick();
        #1;
        chk("busy1_hsel",   32'(s_hsel), 32'd0);
        chk("busy1_m0_rdy", 32'(m0_hready), 32'd1);
        m0_hsel = 1'b0; m0_htrans = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dahb_mem_arb.md
DAHB_MEM_ARB -- requirements
Module: dahb_mem_arb

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-high reset; these are the only clock and reset (ports listed next).
REQ-002 The block SHALL have port pll_core_cpuclk  in  1  core clock; all state on rising edge.
REQ-003 The block SHALL have port pad_cpu_rst  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have, per master i in {0,1}, inputs mi_arb_hsel 1, mi_arb_haddr 32, mi_arb_hsize 3, mi_arb_htrans 2, mi_arb_hwrite 1, mi_arb_hwdata 32, with AHB-lite meaning (m0 = instruction side, m1 = data side).
REQ-005 The block SHALL have, per master i, outputs arb_mi_hrdata 32, arb_mi_hready 1, arb_mi_hresp 2: read data, transfer done, response.
REQ-006 The block SHALL have slave-side outputs arb_mmc_hsel 1, arb_yy_haddr 32, arb_yy_hsize 3, arb_yy_htrans 2, arb_yy_hwrite 1, arb_yy_hwdata 32 toward the memory controller.
REQ-007 The block SHALL have slave-side inputs mmc_arb_hrdata 32, mmc_arb_hready 1, mmc_arb_hresp 2.

Function
REQ-008 A request from master i SHALL be valid in a cycle when mi_arb_hsel=1, mi_arb_htrans[1]=1 and arb_mi_hready=1.
REQ-009 The block SHALL hold one pending register per master (valid bit, haddr, hsize, hwrite), capturing a valid request that is not issued that cycle.
REQ-010 An address phase SHALL be issued to the slave only in a cycle with mmc_arb_hready=1; when mmc_arb_hready=0, no new address phase is issued and all requests go to pending.
REQ-011 Issue priority when mmc_arb_hready=1: pending entries before new requests; among two candidates of equal class, the master not in last_grant wins.
REQ-012 When only one candidate exists, it SHALL be issued in the same cycle (zero added latency: live request drives slave outputs combinationally).
REQ-013 Issuing drives arb_mmc_hsel=1, arb_yy_htrans=2'b10, and haddr/hsize/hwrite from the winner (pending register or live inputs); otherwise arb_mmc_hsel=0, htrans=2'b00.
REQ-014 On issue, last_grant SHALL update to the winner and its pending bit SHALL clear at the clock edge.
REQ-015 FSM states: IDLE (no data phase), DP0 (m0 owns data phase), DP1 (m1 owns data phase).
REQ-016 FSM transitions at a clock edge with mmc_arb_hready=1: to DPi if master i issued this cycle, else to IDLE; with mmc_arb_hready=0, the state SHALL hold.
REQ-017 arb_yy_hwdata SHALL equal m0_arb_hwdata in DP0, m1_arb_hwdata in DP1, and 32'b0 in IDLE.
REQ-018 mmc_arb_hrdata SHALL be broadcast to both arb_mi_hrdata.
REQ-019 arb_mi_hresp SHALL equal mmc_arb_hresp when in DPi, else 2'b00.
REQ-020 arb_mi_hready SHALL be mmc_arb_hready in DPi; 0 when master i's pending bit is set or it is being captured this cycle; otherwise 1.
REQ-021 A master with its pending bit set SHALL see hready=0 until the cycle its pending transfer completes its data phase.
REQ-022 Simultaneous new requests from both masters with no pending: the winner issues and the loser is captured; the loser issues at the next slave-ready cycle.
REQ-023 A pending entry and a new request from the other master in the same cycle: the pending entry issues and the new request is captured.
REQ-024 hsel=1 with htrans IDLE/BUSY SHALL NOT create a request or pending entry.

Reset
REQ-025 When pad_cpu_rst=1, the block SHALL immediately, without a clock, apply: FSM=IDLE, both pending bits=0, last_grant=1 (m0 first), arb_mmc_hsel=0, arb_yy_htrans=0, arb_yy_hwdata=0, arb_mi_hready=1, arb_mi_hresp=0.
REQ-026 Reset asserted mid-transfer SHALL discard pending entries and data-phase ownership; no transfer is replayed after release.

Verification
REQ-027 Single m1 write: m1 haddr=0x2000_0010, hsize=2, hwdata=0xDEADBEEF, slave ready -> same-cycle slave hsel=1; next cycle arb_yy_hwdata=0xDEADBEEF, FSM=DP1.
REQ-028 Both masters request in the same cycle after reset -> m0 issues first, arb_m1_hready=0 for 2 cycles, m1 issues in cycle 2, last_grant=1.
REQ-029 Repeated simultaneous requests for 4 cycles -> grants alternate m0,m1,m0,m1.
REQ-030 Slave stalls (mmc_arb_hready=0 for 3 cycles) in DP1 while m0 requests -> m0 captured pending, no slave issue during stall, m0 issues in the first ready cycle.
REQ-031 pad_cpu_rst pulsed while m1 is pending -> both hready=1, hsel=0 immediately; after release m1 is not issued without a new request.
REQ-032 m0 hsel=1 with htrans=2'b01 (BUSY) -> no slave hsel, arb_m0_hready=1.
